// File: rtl/stage1_top_hwf.sv
// Sequential linear-kernel SVM decision: f = sum_s a[s]*<sv[s],x> + BIAS.
// The pixel and coefficient multipliers are each shared across all vectors.
module stage1_top_hwf #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_OF_SV     = 10,
  parameter int BIAS          = 4000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic y_class
);

  localparam int DOT_W  = 2*XLEN_PIXEL + $clog2(NUM_OF_PIXELS);
  localparam int PROD_W = 2*XLEN_PIXEL;
  localparam int ACC_W  = 48;
  localparam int COEF_W = 16;
  localparam int SW     = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
  localparam int PW     = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;

  localparam logic [SW-1:0] SV_LAST  = SW'(NUM_OF_SV-1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_OF_PIXELS-1);
  localparam logic signed [ACC_W-1:0] ZERO = '0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DOT  = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_BIAS = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Hardwired test vector: x[p] = 10*(p+1).
  function automatic logic [XLEN_PIXEL-1:0] x_rom(input logic [PW-1:0] idx);
    x_rom = XLEN_PIXEL'(10 * (int'(idx) + 1));
  endfunction

  // Every pixel of support vector s holds the value s+1.
  function automatic logic [XLEN_PIXEL-1:0] sv_rom(input logic [SW-1:0] idx);
    sv_rom = XLEN_PIXEL'(int'(idx) + 1);
  endfunction

  // Folded alpha*label: +1 for even vectors, -2 for odd ones.
  function automatic logic signed [COEF_W-1:0] a_rom(input logic [SW-1:0] idx);
    a_rom = idx[0] ? -16'sd2 : 16'sd1;
  endfunction

  logic [2:0]                state;
  logic [SW-1:0]             s_idx;
  logic [PW-1:0]             p_idx;
  logic [DOT_W-1:0]          dot;
  logic signed [ACC_W-1:0]   acc;

  logic [PROD_W-1:0]         pix_prod;
  logic signed [COEF_W-1:0]  a_val;
  logic signed [ACC_W-1:0]   coef_prod;
  logic signed [ACC_W-1:0]   f_val;

  always_comb begin
    pix_prod  = PROD_W'(sv_rom(s_idx)) * PROD_W'(x_rom(p_idx));
    a_val     = a_rom(s_idx);
    coef_prod = ACC_W'(a_val) * $signed(ACC_W'(dot));
    f_val     = acc + ACC_W'(BIAS);
  end

  // en low pauses DOT/MAC/BIAS with every register held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      y_class <= 1'b0;
      acc     <= '0;
      dot     <= '0;
      s_idx   <= '0;
      p_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            acc   <= '0;
            dot   <= '0;
            s_idx <= '0;
            p_idx <= '0;
            state <= S_DOT;
          end
        end
        S_DOT: begin
          if (en) begin
            dot <= dot + DOT_W'(pix_prod);
            if (p_idx == PIX_LAST) begin
              p_idx <= '0;
              state <= S_MAC;
            end else begin
              p_idx <= p_idx + PW'(1);
            end
          end
        end
        S_MAC: begin
          if (en) begin
            acc <= acc + coef_prod;
            dot <= '0;
            if (s_idx == SV_LAST) begin
              state <= S_BIAS;
            end else begin
              s_idx <= s_idx + SW'(1);
              state <= S_DOT;
            end
          end
        end
        S_BIAS: begin
          if (en) begin
            y_class <= (f_val >= ZERO);
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          // Re-arm only after en drops, so one evaluation per en assertion.
          if (!en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage1_top_hwf.sv
// Directed bench for stage1_top_hwf: f=500 (default), f=-500 (BIAS=3000), f=0 (BIAS=3500),
// plus pause, mid-run reset and re-run without glitch.
module tb_stage1_top_hwf;

  logic clk;
  logic rst0, en0, y0;
  logic rst1, en1, y1, y2;

  int checks = 0;
  int errors = 0;

  stage1_top_hwf dut0 (.clk(clk), .rst(rst0), .en(en0), .y_class(y0));
  stage1_top_hwf #(.BIAS(3000)) dut1 (.clk(clk), .rst(rst1), .en(en1), .y_class(y1));
  stage1_top_hwf #(.BIAS(3500)) dut2 (.clk(clk), .rst(rst1), .en(en1), .y_class(y2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
    #2;
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("rst_y0", y0, 1'b0);
    chk("rst_y1", y1, 1'b0);
    chk("rst_y2", y2, 1'b0);
    tick();
    tick();
    chk("rst_hold_y0", y0, 1'b0);
    chk("rst_hold_y2", y2, 1'b0);
    rst0 = 1'b1; rst1 = 1'b1;

    // Run 1: f=500 / -500 / 0, result on edge 52.
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("dflt_e%0d", k), y0, (k >= 52));
      chk($sformatf("b3000_e%0d", k), y1, 1'b0);
      chk($sformatf("b3500_e%0d", k), y2, (k >= 52));
    end

    // Second evaluation after en toggle: y_class must stay 1 throughout.
    en0 = 1'b0;
    tick();
    chk("rerun_idle", y0, 1'b1);
    en0 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("rerun_e%0d", k), y0, 1'b1);
    end

    // Mid-run reset at edge 30 clears y_class asynchronously, then a full restart.
    en0 = 1'b0;
    tick();
    en0 = 1'b1;
    for (int k = 1; k <= 30; k++) tick();
    chk("pre_rst_e30", y0, 1'b1);
    rst0 = 1'b0;
    #1;
    chk("async_rst", y0, 1'b0);
    tick();
    chk("rst_held", y0, 1'b0);
    rst0 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("restart_e%0d", k), y0, (k >= 52));
    end

    // Idle wait with en low after reset; then 5-edge pause mid-DOT moves result to edge 57.
    rst0 = 1'b0;
    #1;
    chk("rst2", y0, 1'b0);
    tick();
    en0 = 1'b0;
    rst0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("idle_wait_%0d", k), y0, 1'b0);
    end
    en0 = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      tick();
      chk($sformatf("pause_e%0d", k), y0, (k >= 57));
      if (k == 8)  en0 = 1'b0;
      if (k == 13) en0 = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage1_top_hwf.md
STAGE1_TOP_HWF -- requirements
Module: stage1_top_hwf

Interface
REQ-001 The module SHALL have parameter XLEN_PIXEL, default 8: pixel and support-vector element width, unsigned.
REQ-002 The module SHALL have parameter NUM_OF_PIXELS, default 4: elements per feature vector.
REQ-003 The module SHALL have parameter NUM_OF_SV, default 10: number of support vectors.
REQ-004 The module SHALL have parameter BIAS, default 4000: signed 32-bit decision bias b.
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port en, input, 1 bit: start/run enable.
REQ-008 Port y_class, output, 1 bit: registered class decision; 1 when f >= 0, else 0.

Function
REQ-009 The module SHALL hold hardwired constant ROMs (no load ports): test vector x, support vectors sv[s][p], signed 16-bit coefficients a[s] (alpha*label folded).
REQ-010 Defaults SHALL be: x = {10,20,30,40}; sv[s][p] = s+1 for every p; a[s] = +1 for even s, -2 for odd s.
REQ-011 The module SHALL compute linear-kernel decision f = sum over s of a[s]*(sum over p of sv[s][p]*x[p]) + BIAS.
REQ-012 Dot products SHALL be unsigned, in a register of at least 2*XLEN_PIXEL+clog2(NUM_OF_PIXELS) bits; the accumulator SHALL be signed 48-bit; no saturation or truncation.
REQ-013 Datapath SHALL use one pixel multiplier and one coefficient multiplier, time-shared.
REQ-014 FSM states SHALL be IDLE, DOT, MAC, BIAS, DONE.
REQ-015 IDLE, en=1 at an edge: clear acc, dot, sv index s, pixel index p; go to DOT. With en=0, remain in IDLE.
REQ-016 DOT, each edge: dot += sv[s][p]*x[p]; p increments; after p = NUM_OF_PIXELS-1, reset p to 0 and go to MAC.
REQ-017 MAC, one edge: acc += a[s]*dot; clear dot; if s = NUM_OF_SV-1 go to BIAS, else increment s and go to DOT.
REQ-018 BIAS, one edge: y_class <= (acc + BIAS >= 0); go to DONE.
REQ-019 DONE: y_class held; go to IDLE only when en=0, so one evaluation runs per en assertion.
REQ-020 In DOT, MAC or BIAS with en=0, all registers SHALL hold (pause); computation resumes when en returns to 1.
REQ-021 Latency from the IDLE edge that samples en=1 to y_class updating SHALL be 1 + NUM_OF_SV*(NUM_OF_PIXELS+1) + 1 edges, which is 52 with defaults.
REQ-022 y_class SHALL change only on the BIAS edge or on reset.
REQ-023 f = 0 exactly SHALL give y_class = 1.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, y_class=0, and acc, dot, s, p = 0, including mid-computation.
REQ-025 After rst returns to 1, no computation SHALL start until en=1 is sampled in IDLE.

Verification
REQ-026 Defaults: rst low, then high; en=1 held. Required: y_class=0 through edge 51, y_class=1 after edge 52 (f=500), then stable.
REQ-027 BIAS=3000, same stimulus. Required: f=-500, y_class stays 0.
REQ-028 BIAS=3500. Required: f=0, y_class=1 after edge 52 (boundary).
REQ-029 Defaults, en dropped for 5 cycles mid-DOT. Required: y_class=1 arrives exactly 5 edges later (edge 57).
REQ-030 Defaults, rst asserted at edge 30, then released with en=1. Required: y_class=0 immediately; full 52-edge run restarts; result 1.
REQ-031 After DONE, en toggled 0 then 1. Required: second run; y_class remains 1 throughout, with no glitch to 0.
